// File: rtl/io_uart_tx_pkg.sv
// Shared types and 8N1 frame constants for the IO UART transmitter.
// FSM state encoding plus line levels used by io_uart_tx.
package io_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Small synchronous FIFO buffering CPU output bytes.
// Push while full is accepted only when a pop happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign empty    = (count == '0);
  assign full     = (count == (AW + 1)'(DEPTH));
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// 8N1 serial transmitter fed by CPU IO writes through a small FIFO.
// Frames run back to back while bytes are queued; tx is registered.
import io_uart_tx_pkg::*;

module io_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                 state;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift;

  logic [DATA_BITS-1:0]   fifo_out;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [CW-1:0]          fifo_count;
  logic                   at_end;
  logic                   pop;

  assign at_end = (baud_cnt == BAUD_MAX);
  assign pop    = ~fifo_empty &
                  ((state == IDLE) | ((state == STOP) & at_end));

  assign busy = (state != IDLE) | (fifo_count != '0);
  assign full = fifo_full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (write),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (fifo_out),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= STOP_LVL;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else begin
      if (write & fifo_full & ~pop) begin
        overflow <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          tx       <= STOP_LVL;
          baud_cnt <= '0;
          if (pop) begin
            shift <= fifo_out;
            tx    <= START_LVL;
            state <= START;
          end
        end
        START: begin
          if (at_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (at_end) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              tx    <= STOP_LVL;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (at_end) begin
            baud_cnt <= '0;
            // Next byte starts with no idle gap between frames.
            if (pop) begin
              shift <= fifo_out;
              tx    <= START_LVL;
              state <= START;
            end else begin
              tx    <= STOP_LVL;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= STOP_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx against a frame-timing model.
// Also decodes the serial line into bytes and compares with the model.
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       write = 1'b0;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .write    (write),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queued bytes plus the frame currently on the line.
  logic [7:0] q[$];
  logic [7:0] sentq[$];
  logic [7:0] rxq[$];
  bit         m_act;
  int         m_s;
  logic [7:0] m_b;
  bit         m_ovf;
  int         cyc = 0;
  int         busy_cnt;

  bit         rx_on;
  int         rx_k0;
  logic [7:0] rx_byte;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_tx();
    int p;
    if (!m_act) return 1'b1;
    p = (cyc - m_s) / CPB;
    if (p == 0) return 1'b0;
    if (p <= 8) return m_b[p-1];
    return 1'b1;
  endfunction

  task automatic step(bit rst, bit wr, logic [7:0] d);
    bit was_full;
    bit popped;
    int off;
    @(negedge clk);
    reset   = rst;
    write   = wr;
    data_in = d;
    cyc++;
    if (rst) begin
      q.delete();
      m_act = 0;
      m_ovf = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      popped   = 0;
      if (m_act && (cyc - m_s == 10 * CPB)) m_act = 0;
      if (!m_act && q.size() > 0) begin
        m_b   = q.pop_front();
        m_s   = cyc;
        m_act = 1;
        popped = 1;
        sentq.push_back(m_b);
      end
      if (wr) begin
        if (!was_full || popped) q.push_back(d);
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    check("tx", tx, exp_tx());
    check("busy", busy, m_act || (q.size() > 0));
    check("full", full, q.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    if (busy) busy_cnt++;
    if (rst) begin
      rx_on = 0;
    end else if (!rx_on && tx == 1'b0) begin
      rx_on = 1;
      rx_k0 = cyc;
    end else if (rx_on) begin
      off = cyc - rx_k0;
      if (off % CPB == 2 && off / CPB >= 1 && off / CPB <= 8)
        rx_byte[off/CPB-1] = tx;
      if (off == 9 * CPB + 2) begin
        check("stop_bit", tx, 1'b1);
        rxq.push_back(rx_byte);
      end
      if (off == 10 * CPB - 1) rx_on = 0;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  task automatic clear_logs();
    sentq.delete();
    rxq.delete();
    busy_cnt = 0;
  endtask

  task automatic compare_logs(string tag);
    check({tag, "_count"}, rxq.size(), sentq.size());
    for (int i = 0; i < rxq.size() && i < sentq.size(); i++)
      check({tag, "_byte"}, rxq[i], sentq[i]);
  endtask

  initial begin
    logic [7:0] ovf_exp [5];
    bit found;
    int phase_pct;

    // Reset and idle line
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    clear_logs();
    idle(100);
    check("idle_busy_cnt", busy_cnt, 0);

    // Single byte A5
    clear_logs();
    step(0, 1, 8'hA5);
    idle(60);
    check("a5_busy_len", busy_cnt, 41);
    check("a5_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("a5_rx", rxq[0], 8'hA5);

    // Back-to-back 00, FF
    clear_logs();
    step(0, 1, 8'h00);
    step(0, 1, 8'hFF);
    idle(100);
    check("b2b_busy_len", busy_cnt, 81);
    compare_logs("b2b");

    // Overflow: 6 writes, last dropped
    clear_logs();
    for (int i = 1; i <= 6; i++) step(0, 1, 8'(i));
    check("ovf_full", full, 1'b1);
    check("ovf_flag", overflow, 1'b1);
    idle(260);
    ovf_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check("ovf_rx_count", rxq.size(), 5);
    for (int i = 0; i < 5 && i < rxq.size(); i++)
      check("ovf_rx", rxq[i], ovf_exp[i]);
    check("ovf_sticky", overflow, 1'b1);

    // Push+pop while full at the STOP->START edge
    step(1, 0, 8'h00);
    clear_logs();
    for (int i = 0; i < 5; i++) step(0, 1, 8'h40 + 8'(i));
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_act && (cyc + 1 - m_s) == 10 * CPB) found = 1;
      else step(0, 0, 8'h00);
    end
    check("pp_edge_found", found, 1'b1);
    check("pp_full_before", full, 1'b1);
    step(0, 1, 8'h99);
    check("pp_no_overflow", overflow, 1'b0);
    idle(300);
    compare_logs("pp");
    check("pp_rx_count", rxq.size(), 6);

    // Reset during DATA bit 3 of 3C with two bytes queued
    step(1, 0, 8'h00);
    clear_logs();
    step(0, 1, 8'h3C);
    step(0, 1, 8'h11);
    step(0, 1, 8'h22);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_act && (cyc + 1 - m_s) / CPB == 4) found = 1;
      else step(0, 0, 8'h00);
    end
    check("rst_point_found", found, 1'b1);
    step(1, 0, 8'h00);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    clear_logs();
    idle(100);
    check("rst_no_frames", rxq.size(), 0);
    check("rst_idle_busy", busy_cnt, 0);

    // Randomized traffic with varying write density
    clear_logs();
    for (int ph = 0; ph < 12; ph++) begin
      phase_pct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 30 : 90);
      for (int i = 0; i < 250; i++)
        step(0, $urandom_range(99) < phase_pct, 8'($urandom));
    end
    idle(300);
    compare_logs("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
